// File: rtl/alu_sequencer_if.sv
// Request, alu_core and architectural-state signals of the ALU sequencer.
// The sequencer uses the slave view; decode plus alu_core form the master view.
interface alu_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [7:0]  req_op_a;
    logic [7:0]  req_op_b;
    logic        req_use_acc;
    logic        req_bit;
    logic        req_bit_mode;
    logic        req_wide;

    logic [4:0]  alu_opcode;
    logic [7:0]  alu_op_a;
    logic [7:0]  alu_op_b;
    logic        alu_cy;
    logic        alu_ac;
    logic        alu_bit;
    logic [7:0]  alu_res_lo;
    logic [7:0]  alu_res_hi;
    logic        alu_cy_o;
    logic        alu_ac_o;
    logic        alu_ov_o;

    logic [7:0]  acc_out;
    logic [7:0]  psw_out;
    logic [15:0] result16;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_opcode, req_op_a, req_op_b, req_use_acc,
               req_bit, req_bit_mode, req_wide,
               alu_res_lo, alu_res_hi, alu_cy_o, alu_ac_o, alu_ov_o,
        output req_ready, alu_opcode, alu_op_a, alu_op_b, alu_cy, alu_ac, alu_bit,
               acc_out, psw_out, result16, done, err
    );

    modport master (
        output req_valid, req_opcode, req_op_a, req_op_b, req_use_acc,
               req_bit, req_bit_mode, req_wide,
               alu_res_lo, alu_res_hi, alu_cy_o, alu_ac_o, alu_ov_o,
        input  req_ready, alu_opcode, alu_op_a, alu_op_b, alu_cy, alu_ac, alu_bit,
               acc_out, psw_out, result16, done, err
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue/capture/commit controller for alu_core owning ACC, PSW and result16; done 3 cycles after accept.
// One request per 4 cycles: req_ready is high only in IDLE, so requests wait while an op is in flight.
module alu_sequencer (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_sequencer_if.slave io_bus
);
    localparam logic [4:0] ALU_ADD  = 5'h01;
    localparam logic [4:0] ALU_ADDC = 5'h02;
    localparam logic [4:0] ALU_SUBB = 5'h03;
    localparam logic [4:0] ALU_INC  = 5'h04;
    localparam logic [4:0] ALU_DEC  = 5'h05;
    localparam logic [4:0] ALU_ANL  = 5'h06;
    localparam logic [4:0] ALU_ORL  = 5'h07;
    localparam logic [4:0] ALU_XRL  = 5'h08;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_COMMIT} state_t;

    state_t      r_state, w_next;
    logic        w_accept;
    logic        r_ready;

    logic [4:0]  r_opcode;
    logic [7:0]  r_op_a, r_op_b;
    logic        r_bit, r_bit_mode, r_wide, r_cy_in, r_ac_in;

    logic [4:0]  r_alu_opcode;
    logic [7:0]  r_alu_op_a, r_alu_op_b;
    logic        r_alu_cy, r_alu_ac, r_alu_bit;

    logic [7:0]  r_res_lo, r_res_hi;
    logic        r_cy_o, r_ac_o, r_ov_o;

    logic [7:0]  r_acc;
    logic        r_cy, r_ac, r_ov;
    logic [15:0] r_result16;
    logic        r_done, r_err;

    logic        w_wr_acc, w_wr_flags, w_wr_cy, w_wr_r16, w_bad;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.req_valid && r_ready) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_COMMIT;
            S_COMMIT:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Write-back decode of the latched request; bit_mode/wide only matter for their own opcodes.
    always_comb begin
        w_wr_acc   = 1'b0;
        w_wr_flags = 1'b0;
        w_wr_cy    = 1'b0;
        w_wr_r16   = 1'b0;
        w_bad      = 1'b0;
        case (r_opcode)
            ALU_ADD, ALU_ADDC, ALU_SUBB: begin
                w_wr_acc   = 1'b1;
                w_wr_flags = 1'b1;
            end
            ALU_DEC, ALU_XRL: w_wr_acc = 1'b1;
            ALU_ANL, ALU_ORL: begin
                if (r_bit_mode) w_wr_cy  = 1'b1;
                else            w_wr_acc = 1'b1;
            end
            ALU_INC: begin
                if (r_wide) w_wr_r16 = 1'b1;
                else        w_wr_acc = 1'b1;
            end
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b0;
            r_opcode     <= 5'h00;
            r_op_a       <= 8'h00;
            r_op_b       <= 8'h00;
            r_bit        <= 1'b0;
            r_bit_mode   <= 1'b0;
            r_wide       <= 1'b0;
            r_cy_in      <= 1'b0;
            r_ac_in      <= 1'b0;
            r_alu_opcode <= 5'h00;
            r_alu_op_a   <= 8'h00;
            r_alu_op_b   <= 8'h00;
            r_alu_cy     <= 1'b0;
            r_alu_ac     <= 1'b0;
            r_alu_bit    <= 1'b0;
            r_res_lo     <= 8'h00;
            r_res_hi     <= 8'h00;
            r_cy_o       <= 1'b0;
            r_ac_o       <= 1'b0;
            r_ov_o       <= 1'b0;
            r_acc        <= 8'h00;
            r_cy         <= 1'b0;
            r_ac         <= 1'b0;
            r_ov         <= 1'b0;
            r_result16   <= 16'h0000;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            // Registered so ready stays low for the first cycle after reset release.
            r_ready <= (w_next == S_IDLE);
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            if (w_accept) begin
                r_opcode   <= io_bus.req_opcode;
                r_op_a     <= io_bus.req_use_acc ? r_acc : io_bus.req_op_a;
                r_op_b     <= io_bus.req_op_b;
                r_bit      <= io_bus.req_bit;
                r_bit_mode <= io_bus.req_bit_mode;
                r_wide     <= io_bus.req_wide;
                r_cy_in    <= r_cy;
                r_ac_in    <= r_ac;
            end

            if (r_state == S_ISSUE) begin
                r_alu_opcode <= r_opcode;
                r_alu_op_a   <= r_op_a;
                r_alu_op_b   <= r_op_b;
                r_alu_cy     <= r_cy_in;
                r_alu_ac     <= r_ac_in;
                r_alu_bit    <= r_bit;
            end

            if (r_state == S_CAPTURE) begin
                r_res_lo <= io_bus.alu_res_lo;
                r_res_hi <= io_bus.alu_res_hi;
                r_cy_o   <= io_bus.alu_cy_o;
                r_ac_o   <= io_bus.alu_ac_o;
                r_ov_o   <= io_bus.alu_ov_o;
            end

            if (r_state == S_COMMIT) begin
                r_done <= 1'b1;
                r_err  <= w_bad;
                if (w_wr_acc) r_acc <= r_res_lo;
                if (w_wr_flags) begin
                    r_cy <= r_cy_o;
                    r_ac <= r_ac_o;
                    r_ov <= r_ov_o;
                end
                if (w_wr_cy)  r_cy       <= r_cy_o;
                if (w_wr_r16) r_result16 <= {r_res_hi, r_res_lo};
            end
        end
    end

    assign io_bus.req_ready  = r_ready & ~i_rst;
    assign io_bus.alu_opcode = r_alu_opcode;
    assign io_bus.alu_op_a   = r_alu_op_a;
    assign io_bus.alu_op_b   = r_alu_op_b;
    assign io_bus.alu_cy     = r_alu_cy;
    assign io_bus.alu_ac     = r_alu_ac;
    assign io_bus.alu_bit    = r_alu_bit;
    assign io_bus.acc_out    = r_acc;
    assign io_bus.psw_out    = {r_cy, r_ac, 3'b000, r_ov, 1'b0, ^r_acc};
    assign io_bus.result16   = r_result16;
    assign io_bus.done       = r_done;
    assign io_bus.err        = r_err;
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural alu_core, directed plan vectors, random requests vs. a reference model.
module tb_alu_sequencer;
    localparam logic [4:0] ALU_ADD  = 5'h01;
    localparam logic [4:0] ALU_ADDC = 5'h02;
    localparam logic [4:0] ALU_SUBB = 5'h03;
    localparam logic [4:0] ALU_INC  = 5'h04;
    localparam logic [4:0] ALU_DEC  = 5'h05;
    localparam logic [4:0] ALU_ANL  = 5'h06;
    localparam logic [4:0] ALU_ORL  = 5'h07;
    localparam logic [4:0] ALU_XRL  = 5'h08;

    typedef struct packed {
        logic [7:0] lo;
        logic [7:0] hi;
        logic       cy;
        logic       ac;
        logic       ov;
    } alu_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0]  m_acc;
    logic        m_cy, m_ac, m_ov;
    logic [15:0] m_r16;

    alu_sequencer_if bus ();
    alu_sequencer dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));

    always #5 clk = ~clk;

    // 8051 arithmetic; flag outputs of non-flag ops are deliberately junk so stray writes show up.
    function automatic alu_t alu_eval(input logic [4:0] opc, input logic [7:0] a, input logic [7:0] b,
                                      input logic cy, input logic ac, input logic bt);
        alu_t        r;
        logic [8:0]  s;
        logic [4:0]  n;
        logic [15:0] w;
        logic        ci;
        r.lo = a ^ b; r.hi = ~a; r.cy = a[7] ^ ac; r.ac = b[3]; r.ov = a[0] ^ b[0];
        ci = (opc == ALU_ADDC) ? cy : 1'b0;
        case (opc)
            ALU_ADD, ALU_ADDC: begin
                s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
                n = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci};
                r.lo = s[7:0]; r.cy = s[8]; r.ac = n[4];
                r.ov = (a[7] == b[7]) && (s[7] != a[7]);
            end
            ALU_SUBB: begin
                s = {1'b0, a} - {1'b0, b} - {8'd0, cy};
                n = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cy};
                r.lo = s[7:0]; r.cy = s[8]; r.ac = n[4];
                r.ov = (a[7] != b[7]) && (s[7] != a[7]);
            end
            ALU_INC: begin
                w = {b, a} + 16'd1;
                r.lo = w[7:0]; r.hi = w[15:8];
            end
            ALU_DEC: r.lo = a - 8'd1;
            ALU_ANL: begin r.lo = a & b; r.cy = cy & bt; end
            ALU_ORL: begin r.lo = a | b; r.cy = cy | bt; end
            ALU_XRL: r.lo = a ^ b;
            default: ;
        endcase
        return r;
    endfunction

    alu_t env_r;
    assign env_r          = alu_eval(bus.alu_opcode, bus.alu_op_a, bus.alu_op_b,
                                     bus.alu_cy, bus.alu_ac, bus.alu_bit);
    assign bus.alu_res_lo = env_r.lo;
    assign bus.alu_res_hi = env_r.hi;
    assign bus.alu_cy_o   = env_r.cy;
    assign bus.alu_ac_o   = env_r.ac;
    assign bus.alu_ov_o   = env_r.ov;

    function automatic logic [7:0] m_psw();
        return {m_cy, m_ac, 3'b000, m_ov, 1'b0, ^m_acc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.req_opcode   = 5'($urandom);
        bus.req_op_a     = 8'($urandom);
        bus.req_op_b     = 8'($urandom);
        bus.req_use_acc  = 1'($urandom);
        bus.req_bit      = 1'($urandom);
        bus.req_bit_mode = 1'($urandom);
        bus.req_wide     = 1'($urandom);
    endtask

    task automatic do_req(input logic [4:0] opc, input logic [7:0] a, input logic [7:0] b,
                          input logic ua, input logic bt, input logic bm, input logic wd);
        logic [7:0] ea;
        logic       e_err;
        logic       cy0;
        alu_t       r;
        int         w;
        @(negedge clk);
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        bus.req_opcode = opc; bus.req_op_a = a; bus.req_op_b = b; bus.req_use_acc = ua;
        bus.req_bit = bt; bus.req_bit_mode = bm; bus.req_wide = wd; bus.req_valid = 1'b1;
        ea  = ua ? m_acc : a;
        cy0 = m_cy;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        scramble();
        chk("ready_busy", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("alu_opcode", bus.alu_opcode, opc);
        chk("alu_op_a", bus.alu_op_a, ea);
        chk("alu_op_b", bus.alu_op_b, b);
        chk("alu_cy", bus.alu_cy, cy0);
        chk("done_t1", bus.done, 0);
        @(posedge clk); #1;
        chk("done_t2", bus.done, 0);
        @(posedge clk); #1;
        r = alu_eval(opc, ea, b, m_cy, m_ac, bt);
        e_err = 1'b0;
        case (opc)
            ALU_ADD, ALU_ADDC, ALU_SUBB: begin m_acc = r.lo; m_cy = r.cy; m_ac = r.ac; m_ov = r.ov; end
            ALU_DEC, ALU_XRL: m_acc = r.lo;
            ALU_ANL, ALU_ORL: if (bm) m_cy = r.cy; else m_acc = r.lo;
            ALU_INC: if (wd) m_r16 = {r.hi, r.lo}; else m_acc = r.lo;
            default: e_err = 1'b1;
        endcase
        chk("done_t3", bus.done, 1);
        chk("err", bus.err, e_err);
        chk("acc", bus.acc_out, m_acc);
        chk("psw", bus.psw_out, m_psw());
        chk("result16", bus.result16, m_r16);
        chk("ready_back", bus.req_ready, 1);
        @(posedge clk); #1;
        chk("done_pulse", bus.done, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] ops [10];
        int         nacc, ndone, last;
        logic       rdy;
        ops = '{ALU_ADD, ALU_ADDC, ALU_SUBB, ALU_INC, ALU_DEC, ALU_ANL, ALU_ORL, ALU_XRL, 5'h1F, 5'h00};
        bus.req_valid = 1'b0;
        scramble();
        m_acc = 8'h00; m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0; m_r16 = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_acc", bus.acc_out, 8'h00);
        chk("rst_psw", bus.psw_out, 8'h00);
        chk("rst_r16", bus.result16, 16'h0000);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_alu", {bus.alu_opcode, bus.alu_op_a, bus.alu_op_b, bus.alu_cy, bus.alu_ac, bus.alu_bit}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("ready_pre_edge", bus.req_ready, 0);
        @(posedge clk); #1;
        chk("ready_post_rst", bus.req_ready, 1);

        do_req(ALU_ADD, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(ALU_ADD, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("plan_add_acc", bus.acc_out, 8'h80);
        chk("plan_add_psw", bus.psw_out, 8'h45);
        do_req(ALU_ADD, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(ALU_ADDC, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan_addc_acc", bus.acc_out, 8'h00);
        chk("plan_addc_psw", bus.psw_out, 8'hC0);
        do_req(ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(ALU_SUBB, 8'h10, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan_subb_acc", bus.acc_out, 8'h0F);
        chk("plan_subb_psw", bus.psw_out, 8'h40);
        do_req(ALU_INC, 8'hFF, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("plan_winc_r16", bus.result16, 16'h1300);
        chk("plan_winc_acc", bus.acc_out, 8'h0F);
        do_req(ALU_ADD, 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        do_req(ALU_ORL, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("plan_orlb_acc", bus.acc_out, 8'h55);
        chk("plan_orlb_psw", bus.psw_out, 8'h80);
        do_req(5'h1F, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("plan_bad_acc", bus.acc_out, 8'h55);
        chk("plan_bad_psw", bus.psw_out, 8'h80);

        for (int i = 0; i < 60; i++) begin
            do_req(ops[$urandom_range(0, 9)], 8'($urandom), 8'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Held-valid throughput: three dependent ADD 0x01 from ACC=0x00.
        do_req(ALU_ADD, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.req_opcode = ALU_ADD; bus.req_op_b = 8'h01; bus.req_use_acc = 1'b1;
        bus.req_bit_mode = 1'b0; bus.req_wide = 1'b0; bus.req_valid = 1'b1;
        nacc = 0; ndone = 0; last = 0;
        for (int c = 0; c < 16; c++) begin
            rdy = bus.req_ready;
            if (bus.done) begin
                ndone++;
                chk("thr_acc", bus.acc_out, ndone);
            end
            if (rdy && bus.req_valid) begin
                if (nacc > 0) chk("thr_gap", c - last, 4);
                last = c;
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc == 3) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        chk("thr_accepts", nacc, 3);
        chk("thr_dones", ndone, 3);
        m_acc = 8'h03; m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0;
        chk("thr_psw", bus.psw_out, m_psw());

        // Reset while the ADD 0x10+0x20 sits in CAPTURE.
        bus.req_opcode = ALU_ADD; bus.req_op_a = 8'h10; bus.req_op_b = 8'h20;
        bus.req_use_acc = 1'b0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_acc", bus.acc_out, 8'h00);
        chk("abort_psw", bus.psw_out, 8'h00);
        chk("abort_ready", bus.req_ready, 0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_done", bus.done, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        m_acc = 8'h00; m_cy = 1'b0; m_ac = 1'b0; m_ov = 1'b0; m_r16 = 16'h0000;
        @(posedge clk); #1;
        chk("abort_ready_rel", bus.req_ready, 1);
        repeat (3) begin
            chk("abort_done_rel", bus.done, 0);
            @(posedge clk); #1;
        end
        do_req(ALU_ADD, 8'h10, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
